mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch requester, data requester and memory port
// signals of the memory arbiter.
//   slave  modport : arbiter view (takes requests, drives grants/memory strobes)
//   master modport : environment view (requesters plus synchronous memory)
// Handshake: a requester raises *_req with its address/data stable and holds it
// until the matching *_gnt (or d_err) pulse; the arbiter answers a granted
// access with exactly one *_rvalid pulse on the following cycle.
interface mem_arbiter_if #(
  parameter int ADDR_W = 9
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between an instruction-fetch
// port and a load/store port. Two-state FSM: IDLE issues at most one access
// (round-robin on contention), WAIT returns the read data / store completion
// to the owner. Misaligned data requests are rejected with d_err.
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset; forces every output to 0
//   bus         mem_arbiter_if.slave (requesters + memory port)
//   busy        high while in WAIT
//   dbg_state_o current FSM state (0 = IDLE, 1 = WAIT)
module mem_arbiter #(
  parameter int ADDR_W = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_arbiter_if.slave         bus,
  output logic                 busy,
  output logic                 dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  state_e state_q, state_d;
  owner_e last_owner_q, last_owner_d;
  owner_e owner_q, owner_d;
  logic   owner_we_q, owner_we_d;

  logic              d_aligned;
  logic              grant_i, grant_d;
  logic              i_gnt, d_gnt, d_err, i_rvalid, d_rvalid;
  logic [31:0]       i_rdata, d_rdata, mem_wdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_D;   // fetch wins the first tie
      owner_q      <= OWN_I;
      owner_we_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      owner_we_q   <= owner_we_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    owner_we_d   = owner_we_q;
    d_aligned    = (bus.d_addr[1:0] == 2'b00);
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    d_err        = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;
    i_rdata      = 32'h0;
    d_rdata      = 32'h0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = 32'h0;
    // Outputs are gated by rst directly so they drop without waiting for the
    // state register to settle.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          d_err   = bus.d_req && !d_aligned;
          // On contention fetch wins only if data went last.
          grant_i = bus.i_req &&
                    (!(bus.d_req && d_aligned) || (last_owner_q == OWN_D));
          grant_d = bus.d_req && d_aligned && !grant_i;
          if (grant_i) begin
            i_gnt        = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = bus.i_addr[ADDR_W-1:0];
            owner_d      = OWN_I;
            owner_we_d   = 1'b0;
            last_owner_d = OWN_I;
            state_d      = WAIT;
          end else if (grant_d) begin
            d_gnt        = 1'b1;
            mem_en       = 1'b1;
            mem_we       = bus.d_we;
            mem_addr     = bus.d_addr[ADDR_W-1:0];
            mem_wdata    = bus.d_wdata;
            owner_d      = OWN_D;
            owner_we_d   = bus.d_we;
            last_owner_d = OWN_D;
            state_d      = WAIT;
          end
        end
        WAIT: begin
          if (owner_q == OWN_I) begin
            i_rvalid = 1'b1;
            i_rdata  = bus.mem_rdata;
          end else begin
            d_rvalid = 1'b1;
            d_rdata  = owner_we_q ? 32'h0 : bus.mem_rdata;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.d_err     = d_err;
  assign bus.i_rvalid  = i_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.i_rdata   = i_rdata;
  assign bus.d_rdata   = d_rdata;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign busy          = !rst && (state_q == WAIT);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int ADDR_W = 9;
  // {i_gnt,d_gnt,d_err,i_rvalid,d_rvalid,mem_en,mem_we,busy,mem_addr,mem_wdata,i_rdata,d_rdata}
  localparam int W = 8 + ADDR_W + 96;

  logic clk, rst, busy, dbg_state;
  logic [W-1:0] exp_q[$];
  int n_tests, n_fail;
  logic [31:0] mem [0:(1<<ADDR_W)-1];

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read memory model, each word preloaded with C0DE0000 | index
  initial begin
    for (int k = 0; k < (1<<ADDR_W); k++) mem[k] = 32'hC0DE_0000 | k;
    bus.mem_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  function automatic logic [W-1:0] mk(
    input logic ig, dg, de, iv, dv, en, we, bz,
    input logic [ADDR_W-1:0] a, input logic [31:0] wd, ir, dr);
    return {ig, dg, de, iv, dv, en, we, bz, a, wd, ir, dr};
  endfunction

  function automatic logic [W-1:0] observe();
    return {bus.i_gnt, bus.d_gnt, bus.d_err, bus.i_rvalid, bus.d_rvalid,
            bus.mem_en, bus.mem_we, busy, bus.mem_addr, bus.mem_wdata,
            bus.i_rdata, bus.d_rdata};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // scoreboard monitor: any cycle with a nonzero output must match the next expected entry
  always @(negedge clk) begin
    logic [W-1:0] obs;
    obs = observe();
    if (!rst && obs != '0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected nothing", obs);
      end else begin
        check("scoreboard", obs, exp_q.pop_front());
      end
    end
    if (bus.i_gnt && bus.d_gnt) check("gnt_exclusive", 1'b1, 1'b0);
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_i(input logic req, input logic [31:0] addr);
    bus.i_req = req; bus.i_addr = addr;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.d_req = req; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    set_i(1'b0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(2);
    check("reset_outputs", observe(), '0);
    check("reset_state", {{(W-1){1'b0}}, dbg_state}, '0);
    // requests during reset must not leak to outputs
    set_i(1'b1, 32'h0040_0010);
    #1;
    check("reset_masks_req", observe(), '0);

    // single fetch
    exp_q.push_back(mk(1,0,0,0,0,1,0,0, 9'h010, 32'h0, 32'h0, 32'h0));
    exp_q.push_back(mk(0,0,0,1,0,0,0,1, 9'h000, 32'h0, 32'hC0DE_0010, 32'h0));
    @(posedge clk); #1; rst = 1'b0;
    cyc(1); set_i(1'b0, 32'h0);
    cyc(1);

    // store then load back
    set_d(1'b1, 1'b1, 32'h24, 32'hDEAD_BEEF);
    exp_q.push_back(mk(0,1,0,0,0,1,1,0, 9'h024, 32'hDEAD_BEEF, 32'h0, 32'h0));
    exp_q.push_back(mk(0,0,0,0,1,0,0,1, 9'h000, 32'h0, 32'h0, 32'h0));
    cyc(1); set_d(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1);
    set_d(1'b1, 1'b0, 32'h24, 32'h0);
    exp_q.push_back(mk(0,1,0,0,0,1,0,0, 9'h024, 32'h0, 32'h0, 32'h0));
    exp_q.push_back(mk(0,0,0,0,1,0,0,1, 9'h000, 32'h0, 32'h0, 32'hDEAD_BEEF));
    cyc(1); set_d(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1);

    // misaligned data request alongside a fetch
    set_i(1'b1, 32'h0000_0104);
    set_d(1'b1, 1'b0, 32'h26, 32'h0);
    exp_q.push_back(mk(1,0,1,0,0,1,0,0, 9'h104, 32'h0, 32'h0, 32'h0));
    exp_q.push_back(mk(0,0,0,1,0,0,0,1, 9'h000, 32'h0, 32'hC0DE_0104, 32'h0));
    cyc(1); set_i(1'b0, 32'h0); set_d(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1);

    // misaligned store alone: error only, no memory access
    set_d(1'b1, 1'b1, 32'h3, 32'h1234_5678);
    exp_q.push_back(mk(0,0,1,0,0,0,0,0, 9'h000, 32'h0, 32'h0, 32'h0));
    cyc(1); set_d(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1);

    // round-robin after reset with both requests held
    rst = 1'b1; cyc(1); rst = 1'b0;
    set_i(1'b1, 32'h0000_0008);
    set_d(1'b1, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(1,0,0,0,0,1,0,0, 9'h008, 32'h0, 32'h0, 32'h0));
      exp_q.push_back(mk(0,0,0,1,0,0,0,1, 9'h000, 32'h0, 32'hC0DE_0008, 32'h0));
      exp_q.push_back(mk(0,1,0,0,0,1,0,0, 9'h010, 32'h0, 32'h0, 32'h0));
      exp_q.push_back(mk(0,0,0,0,1,0,0,1, 9'h000, 32'h0, 32'h0, 32'hC0DE_0010));
    end
    cyc(8);
    set_i(1'b0, 32'h0); set_d(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1);

    // reset while a load is in flight, request held through reset
    set_d(1'b1, 1'b0, 32'h24, 32'h0);
    exp_q.push_back(mk(0,1,0,0,0,1,0,0, 9'h024, 32'h0, 32'h0, 32'h0));
    cyc(1);
    rst = 1'b1;
    #1;
    check("reset_in_wait", observe(), '0);
    check("reset_in_wait_state", {{(W-1){1'b0}}, dbg_state}, '0);
    cyc(1);
    rst = 1'b0;
    exp_q.push_back(mk(0,1,0,0,0,1,0,0, 9'h024, 32'h0, 32'h0, 32'h0));
    exp_q.push_back(mk(0,0,0,0,1,0,0,1, 9'h000, 32'h0, 32'h0, 32'hDEAD_BEEF));
    cyc(1); set_d(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(3);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses never seen, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
